// File: rtl/shift_counter_pkg.sv
// Shared mode encoding and seed values for the shift_counter_gen family.
package shift_counter_pkg;

  typedef enum logic {
    MODE_JOHNSON = 1'b0,
    MODE_RING    = 1'b1
  } mode_e;

  localparam int unsigned MAX_WIDTH = 64;

  // Start-of-sequence value: all zeros for Johnson, bit0 set for ring.
  function automatic logic [MAX_WIDTH-1:0] seed(input logic mode, input int unsigned width);
    logic [MAX_WIDTH-1:0] s;
    s = (mode == MODE_RING) ? MAX_WIDTH'(1) : '0;
    if (width == 0) s = '0;
    return s;
  endfunction

endpackage

// File: rtl/shift_counter_decode.sv
// Combinational legality check and phase-index decode of the counter state.
module shift_counter_decode
  import shift_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PHW   = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] count,
  input  logic             mode_q,
  output logic             legal,
  output logic [PHW-1:0]   phase
);

  localparam logic [PHW:0] TWO_W = (PHW+1)'(2*WIDTH);

  logic [WIDTH-1:0] inv;
  logic [PHW-1:0]   pop;
  logic [PHW-1:0]   idx;
  logic [PHW:0]     back;
  logic             j_legal;
  logic             r_legal;

  always_comb begin
    inv = ~count;
    pop = '0;
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop = pop + PHW'(count[i]);
      if (count[i]) idx = PHW'(i);
    end
    // Johnson states are a run of ones anchored at the LSB, or at the MSB.
    j_legal = ((count & (count + WIDTH'(1))) == '0) || ((inv & (inv + WIDTH'(1))) == '0);
    r_legal = (count != '0) && ((count & (count - WIDTH'(1))) == '0);
    back    = TWO_W - {1'b0, pop};

    legal = (mode_q == MODE_RING) ? r_legal : j_legal;
    phase = '0;
    if (legal) begin
      if (mode_q == MODE_RING)               phase = idx;
      else if (count[0] || (count == '0))    phase = pop;
      else                                   phase = back[PHW-1:0];
    end
  end

endmodule

// File: rtl/shift_counter_gen.sv
// Parametrised Johnson/ring sequence generator with load, self-correction and wrap pulse.
module shift_counter_gen
  import shift_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PHW   = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [PHW-1:0]   phase,
  output logic             wrap,
  output logic             err
);

  logic [WIDTH-1:0] count_q, count_d;
  mode_e            mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] seed_in, seed_cur, step_val;
  logic             legal;

  assign seed_in  = WIDTH'(seed(mode, WIDTH));
  assign seed_cur = WIDTH'(seed(mode_q, WIDTH));

  shift_counter_decode #(.WIDTH(WIDTH), .PHW(PHW)) u_decode (
    .count  (count_q),
    .mode_q (mode_q),
    .legal  (legal),
    .phase  (phase)
  );

  always_comb begin
    if (mode_q == MODE_RING)
      step_val = dir ? {count_q[0], count_q[WIDTH-1:1]} : {count_q[WIDTH-2:0], count_q[WIDTH-1]};
    else
      step_val = dir ? {~count_q[0], count_q[WIDTH-1:1]} : {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
  end

  always_comb begin
    count_d = count_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    err_d   = err_q;
    if (load) begin
      count_d = load_val;
      err_d   = 1'b0;
    end else if (mode_e'(mode) != mode_q) begin
      count_d = seed_in;
      mode_d  = mode_e'(mode);
    end else if (!legal) begin
      count_d = seed_cur;
      err_d   = 1'b1;
    end else if (en) begin
      count_d = step_val;
      wrap_d  = (step_val == seed_cur);
    end
  end

  // Reset seeds from the live mode input so the first sequence matches it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= seed_in;
      mode_q  <= mode_e'(mode);
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_shift_counter_gen.sv
// Scoreboard bench for shift_counter_gen (WIDTH=4) with directed vectors.
module tb_shift_counter_gen;

  logic       clk = 1'b0;
  logic       reset, en, dir, mode, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic [2:0] phase;
  logic       wrap, err;

  shift_counter_gen #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .phase    (phase),
    .wrap     (wrap),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] c;
    logic [2:0] p;
    logic       w;
    logic       e;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event ev_async;

  task automatic cmp(input string tag, input string field, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %b expected %b", tag, field, act, exp);
    end
  endtask

  task automatic drv(input logic en_v, input logic dir_v, input logic mode_v, input logic load_v,
                     input logic [3:0] lv, input logic [3:0] c, input logic [2:0] p,
                     input logic w, input logic e, input string tag);
    exp_t x;
    @(negedge clk);
    en = en_v; dir = dir_v; mode = mode_v; load = load_v; load_val = lv;
    x.c = c; x.p = p; x.w = w; x.e = e; x.tag = tag;
    sb.push_back(x);
  endtask

  // Monitor: every edge (or async event) with a pending expectation is checked.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk or ev_async);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        cmp(x.tag, "count", count, x.c);
        cmp(x.tag, "phase", {1'b0, phase}, {1'b0, x.p});
        cmp(x.tag, "wrap", {3'b0, wrap}, {3'b0, x.w});
        cmp(x.tag, "err", {3'b0, err}, {3'b0, x.e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] j_up [8];
    logic [3:0] j_dn [8];
    logic [3:0] r_up [4];
    exp_t a;
    int   wait_cyc;
    j_up = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    j_dn = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    r_up = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = 4'b0;
    drv(0, 0, 0, 0, 4'b0, 4'b0000, 3'd0, 0, 0, "rst0");
    drv(0, 0, 0, 0, 4'b0, 4'b0000, 3'd0, 0, 0, "rst1");
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 8; i++)
      drv(1, 0, 0, 0, 4'b0, j_up[i], 3'((i + 1) % 8), (i == 7), 0, "j_up");
    for (int i = 0; i < 8; i++)
      drv(1, 1, 0, 0, 4'b0, j_dn[i], 3'(7 - i), (i == 7), 0, "j_dn");

    drv(1, 0, 0, 0, 4'b0, 4'b0001, 3'd1, 0, 0, "pre_sw0");
    drv(1, 0, 0, 0, 4'b0, 4'b0011, 3'd2, 0, 0, "pre_sw1");
    drv(1, 0, 1, 0, 4'b0, 4'b0001, 3'd0, 0, 0, "mode_sw");
    for (int i = 0; i < 4; i++)
      drv(1, 0, 1, 0, 4'b0, r_up[i], 3'((i + 1) % 4), (i == 3), 0, "r_up");
    drv(1, 1, 1, 0, 4'b0, 4'b1000, 3'd3, 0, 0, "r_dn_wrap");
    drv(0, 0, 0, 0, 4'b0, 4'b0000, 3'd0, 0, 0, "to_j");

    drv(0, 0, 0, 1, 4'b0101, 4'b0101, 3'd0, 0, 0, "ld_bad");
    drv(0, 0, 0, 0, 4'b0,    4'b0000, 3'd0, 0, 1, "fix");
    drv(1, 0, 0, 0, 4'b0,    4'b0001, 3'd1, 0, 1, "sticky_step");
    drv(0, 0, 0, 0, 4'b0,    4'b0001, 3'd1, 0, 1, "sticky_hold");
    drv(0, 0, 0, 1, 4'b0011, 4'b0011, 3'd2, 0, 0, "ld_clr");

    for (int i = 0; i < 5; i++)
      drv(0, 1'(i % 2), 0, 0, 4'b0, 4'b0011, 3'd2, 0, 0, "hold");
    drv(0, 0, 1, 1, 4'b0111, 4'b0111, 3'd3, 0, 0, "ld_vs_mode");
    drv(0, 0, 1, 0, 4'b0,    4'b0001, 3'd0, 0, 0, "mode_after_ld");
    drv(0, 0, 1, 1, 4'b0011, 4'b0011, 3'd0, 0, 0, "ring_ld_bad");
    drv(0, 0, 1, 0, 4'b0,    4'b0001, 3'd0, 0, 1, "ring_fix");
    drv(0, 0, 0, 0, 4'b0,    4'b0000, 3'd0, 0, 1, "to_j_err");

    for (int i = 0; i < 5; i++)
      drv(1, 0, 0, 0, 4'b0, j_up[i], 3'(i + 1), 0, 1, "pre_rst");
    @(negedge clk);
    en = 1'b1; reset = 1'b0;
    #1;
    a.c = 4'b0000; a.p = 3'd0; a.w = 1'b0; a.e = 1'b0; a.tag = "async_rst";
    sb.push_back(a);
    -> ev_async;
    drv(1, 0, 0, 0, 4'b0, 4'b0000, 3'd0, 0, 0, "rst_held0");
    drv(1, 0, 0, 0, 4'b0, 4'b0000, 3'd0, 0, 0, "rst_held1");
    @(negedge clk); reset = 1'b1; en = 1'b0;
    drv(1, 0, 0, 0, 4'b0, 4'b0001, 3'd1, 0, 0, "resume");
    drv(1, 0, 0, 0, 4'b0, 4'b0011, 3'd2, 0, 0, "resume2");

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
    end
    en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
